mfsk_modulator: RTL
===================

// Module: mfsk_modulator
// PURPOSE
//   Parametrised M-ary FSK modulator (M = 2^BITS_PER_SYM: 2/4/8/16 tones), next generation of the BFSK modulator.
//   Emits a sync preamble, then a phase-continuous I/Q (cos/sine) tone burst per symbol.
//   Symbols arrive through a valid/ready handshake with frame delimiting.
//   Sits between the framing/symbol source and the DAC/channel model; pairs with the matching M-FSK demodulator.
// PARAMETERS
//   BITS_PER_SYM     1      bits per symbol (1..4); tone count M = 2^BITS_PER_SYM
//   PHASE_WIDTH      16     phase accumulator width
//   ROM_ADDR_WIDTH   10     sine ROM address width; ROM holds 2^ROM_ADDR_WIDTH full-cycle entries (>=2)
//   ROM_WIDTH        16     signed ROM sample width
//   OUT_WIDTH        18     signed output width (>= ROM_WIDTH; ROM samples sign-extended)
//   AMPLITUDE        16383  ROM peak: rom[i] = $rtoi(AMPLITUDE*sin(2*pi*i/2^ROM_ADDR_WIDTH))
//   BASE_INC         655    phase increment of tone 0
//   STEP_INC         656    increment spacing: inc(k) = BASE_INC + k*STEP_INC, mod 2^PHASE_WIDTH
//   SAMPLES_PER_SYM  64     output samples per symbol (>=2)
//   SYNC_LENGTH      10     preamble length in samples (>=1)
// PORTS
//   clk          in   1               system clock, all logic on rising edge
//   reset_n      in   1               asynchronous active-low reset
//   start        in   1               frame start request; sampled in IDLE only
//   sym_data     in   BITS_PER_SYM    symbol value
//   sym_last     in   1               accompanies the final symbol of a frame
//   sym_valid    in   1               sym_data/sym_last valid
//   sym_ready    out  1               symbol accepted when sym_valid & sym_ready
//   sine_out     out  OUT_WIDTH       signed sine (Q) sample
//   cos_out      out  OUT_WIDTH       signed cosine (I) sample
//   out_valid    out  1               sine_out/cos_out carry a preamble or tone sample
//   busy         out  1               state != IDLE
//   frame_done   out  1               1-cycle pulse: last sample of the sym_last symbol has been issued
//   underrun     out  1               1-cycle pulse: no symbol at a boundary; frame aborted
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE, acc=0, inc=0, cnt=0; every output is 0. Takes effect mid-frame immediately.
//   States: IDLE -> SYNC -> DATA -> IDLE.
//   - IDLE: start=1 -> SYNC with cnt=0, acc=0. Other inputs ignored.
//   - SYNC: one sample per cycle, cnt counts 0..SYNC_LENGTH-1. sym_ready=1 only at cnt=SYNC_LENGTH-1.
//   - DATA: cnt counts 0..SAMPLES_PER_SYM-1. sym_ready=1 only at cnt=SAMPLES_PER_SYM-1, and only if the current symbol is not last.
//   - Boundary cycle (sym_ready=1):
//       sym_valid=1 -> latch inc(map(sym_data)) and sym_last; go to/stay in DATA with cnt=0.
//       sym_valid=0 -> underrun pulse; go to IDLE.
//   - Last-symbol boundary (latched sym_last=1, cnt=SAMPLES_PER_SYM-1): frame_done pulse; go to IDLE; sym_ready stays 0.
//   - start while busy: ignored. sym_ready is combinational from state/cnt/latched last; it never depends on sym_valid.
//   Datapath:
//   - In DATA each cycle: acc <= acc + inc (mod 2^PHASE_WIDTH).
//   - acc is NOT cleared between symbols, giving phase-continuous tone switches.
//   - sin_addr = acc[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH]; cos_addr = sin_addr + 2^(ROM_ADDR_WIDTH-2), which wraps.
//   - If ROM_ADDR_WIDTH > PHASE_WIDTH, acc is left-aligned (zero-padded LSBs).
//   - The sample uses acc before the increment of that cycle.
//   Output register, 1-cycle latency from state:
//   - A SYNC cycle yields sine_out = 2^(OUT_WIDTH-1)-1, cos_out = 0, out_valid = 1.
//   - A DATA cycle yields sign-extended rom[sin_addr] / rom[cos_addr], out_valid = 1.
//   - An IDLE cycle yields sine_out = cos_out = 0, out_valid = 0.
//   - frame_done and underrun are registered with the same 1-cycle alignment, coincident with the output cycle following the final sample.
//   Arithmetic: inc computed as (BASE_INC + k*STEP_INC) truncated to PHASE_WIDTH; no overflow flag.
// CONFIGURATION
//   MFSK_GRAY_EN defined: tone index k = gray-to-binary(sym_data), so adjacent tones differ in one bit.
//   MFSK_GRAY_EN undefined: k = sym_data (natural binary).
//   BITS_PER_SYM=1 is identical either way.
// TESTING
//   1) BITS_PER_SYM=1, SPS=4, SYNC=3; pulse start
//      -> busy next cycle; 3 out_valid cycles of sine_out=18'h1FFFF, cos_out=0; sym_ready high in the 3rd SYNC cycle.
//   2) Symbols 0 then 1 back-to-back (BASE 655, STEP 656)
//      -> acc samples 0,655,1310,1965, then 2620,3931,5242,6553 (continuous, no reset); cos leads sine by 90 deg.
//   3) sym_valid=0 at a DATA boundary
//      -> underrun 1-cycle pulse; out_valid=0 and outputs 0 on following cycle; busy=0; acc cleared on next start.
//   4) Symbol with sym_last=1
//      -> SPS samples issued, sym_ready held 0 at its boundary, frame_done pulse once, then IDLE; start during busy has no effect.
//   5) reset_n low for 1 cycle mid-symbol
//      -> all outputs 0 immediately (asynchronous); after release, IDLE until start.
//   6) BITS_PER_SYM=2, sym_data=2'b11
//      -> with MFSK_GRAY_EN inc=1967 (k=2); without it inc=2623 (k=3); checked via acc step between samples.

Source files
------------

// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: sync preamble followed by phase-continuous I/Q tone
// bursts, one burst of SAMPLES_PER_SYM samples per accepted symbol.
// Optional build macro: MFSK_GRAY_EN (gray-coded symbol to tone mapping).
module mfsk_modulator #(
  parameter int BITS_PER_SYM    = 1,
  parameter int PHASE_WIDTH     = 16,
  parameter int ROM_ADDR_WIDTH  = 10,
  parameter int ROM_WIDTH       = 16,
  parameter int OUT_WIDTH       = 18,
  parameter int AMPLITUDE       = 16383,
  parameter int BASE_INC        = 655,
  parameter int STEP_INC        = 656,
  parameter int SAMPLES_PER_SYM = 64,
  parameter int SYNC_LENGTH     = 10
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [BITS_PER_SYM-1:0]     sym_data,
  input  logic                        sym_last,
  input  logic                        sym_valid,
  output logic                        sym_ready,
  output logic signed [OUT_WIDTH-1:0] sine_out,
  output logic signed [OUT_WIDTH-1:0] cos_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        underrun
);

  localparam real PI        = 3.14159265358979323846;
  localparam int  ROM_DEPTH = 1 << ROM_ADDR_WIDTH;
  localparam int  CNT_MAX   = (SAMPLES_PER_SYM > SYNC_LENGTH) ? SAMPLES_PER_SYM : SYNC_LENGTH;
  localparam int  CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int  EXT_W     = (PHASE_WIDTH > ROM_ADDR_WIDTH) ? PHASE_WIDTH : ROM_ADDR_WIDTH;
  localparam logic signed [OUT_WIDTH-1:0] SYNC_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0]        acc_q, acc_d;
  logic [PHASE_WIDTH-1:0]        inc_q, inc_d;
  logic                          last_q, last_d;
  logic signed [OUT_WIDTH-1:0]   sine_q, sine_d;
  logic signed [OUT_WIDTH-1:0]   cos_q, cos_d;
  logic                          out_valid_q, out_valid_d;
  logic                          frame_done_q, frame_done_d;
  logic                          underrun_q, underrun_d;

  logic signed [ROM_WIDTH-1:0]   rom [ROM_DEPTH];
  logic [EXT_W-1:0]              acc_ext;
  logic [ROM_ADDR_WIDTH-1:0]     sin_addr;
  logic [ROM_ADDR_WIDTH-1:0]     cos_addr;
  logic                          sync_end;
  logic                          sym_end;

  // Symbol value to tone index (gray decode when enabled)
  function automatic logic [BITS_PER_SYM-1:0] tone_index(input logic [BITS_PER_SYM-1:0] s);
`ifdef MFSK_GRAY_EN
    logic [BITS_PER_SYM-1:0] b;
    b[BITS_PER_SYM-1] = s[BITS_PER_SYM-1];
    for (int i = BITS_PER_SYM - 2; i >= 0; i--) b[i] = b[i+1] ^ s[i];
    return b;
`else
    return s;
`endif
  endfunction

  // Tone index to phase increment, wrapping modulo the accumulator width
  function automatic logic [PHASE_WIDTH-1:0] tone_inc(input logic [BITS_PER_SYM-1:0] k);
    return PHASE_WIDTH'(BASE_INC + int'(k) * STEP_INC);
  endfunction

  // Sign-extend a ROM sample to the output width
  function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [ROM_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction

  // Full-cycle sine table, elaborated from the amplitude parameter
  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(gi) / real'(ROM_DEPTH);
    assign rom[gi] = ROM_WIDTH'($rtoi(real'(AMPLITUDE) * $sin(ANG)));
  end

  // Left-align the accumulator on the ROM address; cosine is a quarter turn ahead
  assign acc_ext  = EXT_W'(acc_q) << (EXT_W - PHASE_WIDTH);
  assign sin_addr = ROM_ADDR_WIDTH'(acc_ext >> (EXT_W - ROM_ADDR_WIDTH));
  assign cos_addr = sin_addr + ROM_ADDR_WIDTH'(ROM_DEPTH / 4);

  assign sync_end  = (state_q == S_SYNC) && (cnt_q == CNT_W'(SYNC_LENGTH - 1));
  assign sym_end   = (state_q == S_DATA) && (cnt_q == CNT_W'(SAMPLES_PER_SYM - 1));
  assign sym_ready = sync_end || (sym_end && !last_q);

  // Next-state, phase and output-sample computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    inc_d        = inc_q;
    last_d       = last_q;
    sine_d       = '0;
    cos_d        = '0;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;

    case (state_q)
      S_SYNC: begin
        sine_d      = SYNC_VAL;
        out_valid_d = 1'b1;
      end
      S_DATA: begin
        sine_d      = sext(rom[sin_addr]);
        cos_d       = sext(rom[cos_addr]);
        out_valid_d = 1'b1;
        acc_d       = acc_q + inc_q;
      end
      default: ;
    endcase

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_SYNC;
        cnt_d   = '0;
        acc_d   = '0;
      end
    end else if (sym_ready) begin
      cnt_d = '0;
      if (sym_valid) begin
        state_d = S_DATA;
        inc_d   = tone_inc(tone_index(sym_data));
        last_d  = sym_last;
      end else begin
        state_d    = S_IDLE;
        underrun_d = 1'b1;
      end
    end else if (sym_end) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      frame_done_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      inc_q        <= '0;
      last_q       <= 1'b0;
      sine_q       <= '0;
      cos_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      inc_q        <= inc_d;
      last_q       <= last_d;
      sine_q       <= sine_d;
      cos_q        <= cos_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sine_out   = sine_q;
  assign cos_out    = cos_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
